// File: rtl/debounced_encoder4to2_pkg.sv
// Shared definitions for the debounced 4-to-2 key encoder: idle key pattern,
// FSM state type and the active-low priority encoder.
package enc_pkg;

    localparam logic [3:0] KEY_NONE = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    typedef struct packed {
        logic       any;
        logic       multi;
        logic [1:0] code;
    } enc_t;

    // Active-low priority encoder: lowest pressed index wins; no key gives code 0.
    function automatic enc_t prio_enc4(input logic [3:0] n);
        enc_t        r;
        int unsigned lows;
        r    = '0;
        lows = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!n[i]) begin
                if (!r.any) begin
                    r.code = i[1:0];
                end
                r.any = 1'b1;
                lows++;
            end
        end
        r.multi = (lows >= 2);
        return r;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-bit synchroniser plus debouncer. Idle level of every line is high.
// A synced pattern must be seen unchanged for DEBOUNCE_CYCLES consecutive
// clocks before it is copied to stable.
module sync_debounce #(
    parameter int unsigned W               = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable
);

    localparam int unsigned    CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [W-1:0]     sync_r [SYNC_STAGES];
    logic [W-1:0]     sync_q;
    logic [W-1:0]     candidate;
    logic [CNT_W-1:0] count;

    assign sync_q = sync_r[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous input lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '1;
            end
        end else begin
            sync_r[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Candidate/count debounce. stable is loaded on the same edge that count
    // reaches DEBOUNCE_CYCLES-1, so exactly DEBOUNCE_CYCLES equal synced samples
    // (the loading one included) are needed; count then saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= '1;
            count     <= '0;
            stable    <= '1;
        end else if (sync_q != candidate) begin
            candidate <= sync_q;
            count     <= '0;
        end else begin
            if (count != CNT_LAST) begin
                count <= count + 1'b1;
            end
            if (count >= CNT_ACCEPT) begin
                stable <= candidate;
            end
        end
    end

endmodule

// File: rtl/debounced_encoder4to2.sv
// Debounced 4-to-2 key encoder for active-low pushbuttons.
// Optional build macro: AUTOREPEAT_EN (press re-pulses every REPEAT_CYCLES
// clocks while a key is held).
// release is a reserved word in SystemVerilog, so the key-up pulse is named released.
module debounced_encoder4to2
    import enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_n,
    output logic [1:0] code,
    output logic       valid,
    output logic       multi,
    output logic       press,
    output logic       released
);

    logic [3:0] stable;
    enc_t       enc;
    state_t     state;
    state_t     state_nxt;
    logic       press_nxt;
    logic       release_nxt;
    logic       rep_fire;

    sync_debounce #(
        .W              (4),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_n),
        .stable(stable)
    );

    assign enc = prio_enc4(stable);

`ifdef AUTOREPEAT_EN
    localparam int unsigned      REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic [3:0]       key_q;
    logic             key_chg;

    assign key_chg  = (stable != key_q);
    assign rep_fire = (state == HELD) && !key_chg && (rep_cnt == REP_LAST);

    // Repeat timer: cleared outside HELD (so it starts at 0 on entry), on a
    // key change and after each repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            key_q   <= KEY_NONE;
        end else begin
            key_q <= stable;
            if ((state != HELD) || key_chg || (rep_cnt == REP_LAST)) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    // REPEAT_CYCLES has no effect without auto-repeat.
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
    assign rep_fire      = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and press/release pulse decode.
    always_comb begin
        state_nxt   = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc.any) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end
            end
            HELD: begin
                if (!enc.any) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (rep_fire) begin
                    press_nxt = 1'b1;
                end
            end
        endcase
    end

    // Output registers, one clock behind stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code     <= '0;
            valid    <= 1'b0;
            multi    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            code     <= enc.code;
            valid    <= enc.any;
            multi    <= enc.multi;
            press    <= press_nxt;
            released <= release_nxt;
        end
    end

endmodule
